// File: rtl/reg_bus_arbiter.sv
// Two-port arbiter and sequencer that serialises register accesses onto one reg_wr/reg_rd port.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module reg_bus_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          reg_wr,
    output logic [AW-1:0] reg_waddr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_rd,
    output logic [AW-1:0] reg_raddr,
    input  logic [DW-1:0] reg_rdata,
    output logic          arb_busy,
    output logic          arb_gnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          gnt_q, gnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          win;

    // Winner is only meaningful when at least one request is high.
`ifdef REG_ARB_ROUND_ROBIN_EN
    assign win = (m0_req && m1_req) ? ~gnt_q : ~m0_req;
`else
    assign win = ~m0_req;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = gnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d   = win;
                    we_d    = win ? m1_we    : m0_we;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = we_q ? ACK : RD_WAIT;
            end
            RD_WAIT: begin
                // Register file returns data one cycle after the read strobe.
                if (gnt_q) begin
                    rdata1_d = reg_rdata;
                end else begin
                    rdata0_d = reg_rdata;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign reg_wr    = (state_q == ISSUE) && we_q;
    assign reg_rd    = (state_q == ISSUE) && !we_q;
    assign reg_waddr = addr_q;
    assign reg_raddr = addr_q;
    assign reg_wdata = wdata_q;
    assign m0_ack    = (state_q == ACK) && !gnt_q;
    assign m1_ack    = (state_q == ACK) && gnt_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign arb_busy  = (state_q != IDLE);
    assign arb_gnt   = gnt_q;

endmodule
